// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and address helper for the pair engine.
// Used by the engine, its MAC lanes, and the RAM/result-store blocks.
package matmul_pkg;
  localparam int N    = 8;
  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int IW   = $clog2(N);
  localparam int ACCW = 2*DW + IW;

  localparam logic [IW-1:0] LAST_I = IW'(N-1);
  localparam logic [IW-1:0] LAST_J = IW'(N-2);
  localparam logic [IW-1:0] LAST_K = IW'(N-1);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, OUT, DONE
  } state_e;

  // Row-major RAM address of element (r, c).
  function automatic logic [AW-1:0] rc_addr(
    input logic [IW-1:0] r,
    input logic [IW-1:0] c
  );
    return AW'(r) * AW'(N) + AW'(c);
  endfunction
endpackage

// File: rtl/matmul_pair_engine_mac_lane.sv
// One signed multiply-accumulate lane: load on first term, add afterwards.
// Ports: clk, rst_n, en, load, a, b in; acc out (ACCW signed).
module mac_lane
  import matmul_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_x;
  logic signed [ACCW-1:0] acc_d;
  logic signed [ACCW-1:0] acc_q;

  assign prod   = a * b;
  assign prod_x = ACCW'(prod);

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = load ? prod_x : acc_q + prod_x;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/matmul_pair_engine.sv
// C = A x B engine producing C[i][j], C[i][j+1] per pass over k.
// Ports: start/busy/done control, A and dual B read ports, c_* valid/ready output.
module matmul_pair_engine
  import matmul_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          a_addr,
  input  logic signed [DW-1:0]   a_data,
  output logic [AW-1:0]          b_addr1,
  output logic [AW-1:0]          b_addr2,
  input  logic signed [DW-1:0]   b_data1,
  input  logic signed [DW-1:0]   b_data2,
  output logic                   c_valid,
  input  logic                   c_ready,
  output logic [IW-1:0]          c_row,
  output logic [IW-1:0]          c_col,
  output logic signed [ACCW-1:0] c_data0,
  output logic signed [ACCW-1:0] c_data1
);
  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] k_q, k_d;
  logic [AW-1:0] a_addr_q, a_addr_d;
  logic [AW-1:0] b1_q, b1_d;
  logic [AW-1:0] b2_q, b2_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          vld_q, vld_d;
  logic          en_q, en_d;
  logic          ld_q, ld_d;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    vld_d    = vld_q;
    // RAM data for the k on the address bus lands next cycle.
    en_d     = (state_q == RUN);
    ld_d     = (state_q == RUN) && (k_q == '0);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (k_q == LAST_K) state_d = DRAIN;
        else               k_d     = k_q + IW'(1);
      end
      DRAIN: begin
        state_d = OUT;
        vld_d   = 1'b1;
      end
      OUT: begin
        if (c_ready) begin
          vld_d = 1'b0;
          if (i_q == LAST_I && j_q == LAST_J) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            k_d     = '0;
            if (j_q == LAST_J) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(2);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    a_addr_d = a_addr_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    // Addresses move only while issuing; they freeze otherwise.
    if (state_d == RUN) begin
      a_addr_d = rc_addr(i_d, k_d);
      b1_d     = rc_addr(k_d, j_d);
      b2_d     = rc_addr(k_d, j_d + IW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_addr_q <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
      en_q     <= 1'b0;
      ld_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_addr_q <= a_addr_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vld_q    <= vld_d;
      en_q     <= en_d;
      ld_q     <= ld_d;
    end
  end

  mac_lane u_lane0 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .load  (ld_q),
    .a     (a_data),
    .b     (b_data1),
    .acc   (c_data0)
  );

  mac_lane u_lane1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .load  (ld_q),
    .a     (a_data),
    .b     (b_data2),
    .acc   (c_data1)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_valid = vld_q;
  assign a_addr  = a_addr_q;
  assign b_addr1 = b1_q;
  assign b_addr2 = b2_q;
  assign c_row   = i_q;
  assign c_col   = j_q;
endmodule

// File: tb/tb_matmul_pair_engine.sv
// Bench for matmul_pair_engine with registered-read A/B RAM models.
// Results are compared against a plain matrix-product reference.
module tb_matmul_pair_engine;
  import matmul_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [AW-1:0]          a_addr;
  logic signed [DW-1:0]   a_data;
  logic [AW-1:0]          b_addr1;
  logic [AW-1:0]          b_addr2;
  logic signed [DW-1:0]   b_data1;
  logic signed [DW-1:0]   b_data2;
  logic                   c_valid;
  logic                   c_ready;
  logic [IW-1:0]          c_row;
  logic [IW-1:0]          c_col;
  logic signed [ACCW-1:0] c_data0;
  logic signed [ACCW-1:0] c_data1;

  matmul_pair_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_data(a_data),
    .b_addr1(b_addr1), .b_addr2(b_addr2),
    .b_data1(b_data1), .b_data2(b_data2),
    .c_valid(c_valid), .c_ready(c_ready),
    .c_row(c_row), .c_col(c_col),
    .c_data0(c_data0), .c_data1(c_data1)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] amem [N*N];
  logic signed [DW-1:0] bmem [N*N];

  always @(posedge clk) begin
    a_data  <= amem[a_addr];
    b_data1 <= bmem[b_addr1];
    b_data2 <= bmem[b_addr2];
  end

  int checks = 0;
  int errors = 0;
  int exp_c [N][N];
  int q_row[$], q_col[$], q_d0[$], q_d1[$];
  int stall_seen, stall_diff, busy_low, addr_bad;

  function automatic void build_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++)
          s += int'(amem[i*N+k]) * int'(bmem[k*N+j]);
        exp_c[i][j] = s;
      end
  endfunction

  // Count of pairs that differ from row-major reference order/values.
  function automatic int seq_errs(output int first);
    int e = 0;
    first = -1;
    if (q_row.size() != N*N/2) begin
      e++;
      first = q_row.size();
    end
    for (int p = 0; p < q_row.size() && p < N*N/2; p++) begin
      int r = p / (N/2);
      int c = (p % (N/2)) * 2;
      if (q_row[p] != r || q_col[p] != c ||
          q_d0[p] != exp_c[r][c] || q_d1[p] != exp_c[r][c+1]) begin
        e++;
        if (first < 0) first = p;
      end
    end
    return e;
  endfunction

  task automatic fill_rand();
    for (int x = 0; x < N*N; x++) begin
      amem[x] = DW'($urandom);
      bmem[x] = DW'($urandom);
    end
  endtask

  task automatic run_job(input int stall_pair, input int stall_len,
                         input bit poke, input bit rnd_ready,
                         output int done_cyc, output bit tmo);
    int stalled;
    logic [127:0] snap;
    q_row.delete(); q_col.delete(); q_d0.delete(); q_d1.delete();
    stall_diff = 0; busy_low = 0; addr_bad = 0;
    done_cyc = -1; tmo = 1'b1; stalled = 0; snap = '0;
    build_ref();
    @(negedge clk);
    start = 1'b1;
    c_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int edges = 0; edges < 3000; edges++) begin
      @(negedge clk);
      start = poke && busy && (edges % 3 == 1);
      if (a_addr > AW'(N*N-1) || b_addr1 > AW'(N*N-1) || b_addr2 > AW'(N*N-1))
        addr_bad++;
      if (done) begin
        done_cyc = edges + 1;
        tmo = 1'b0;
        break;
      end
      if (!busy) busy_low++;
      c_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (c_valid && q_row.size() == stall_pair && stalled < stall_len) begin
        if (stalled == 0)
          snap = {60'd0, c_row, c_col, c_data0, c_data1, a_addr, b_addr1, b_addr2};
        else if ({60'd0, c_row, c_col, c_data0, c_data1, a_addr, b_addr1, b_addr2} !== snap)
          stall_diff++;
        stalled++;
        c_ready = 1'b0;
      end
      if (c_valid && c_ready) begin
        q_row.push_back(int'(c_row));
        q_col.push_back(int'(c_col));
        q_d0.push_back(int'(c_data0));
        q_d1.push_back(int'(c_data1));
      end
      @(posedge clk);
    end
    start = 1'b0;
    c_ready = 1'b1;
    stall_seen = stalled;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; c_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, c_valid, a_addr, b_addr1, b_addr2, c_row, c_col, c_data0, c_data1} !== '0) begin
      errors++;
      $display("FAIL reset_values busy=%b done=%b vld=%b a=%0d b1=%0d b2=%0d want all 0",
               busy, done, c_valid, a_addr, b_addr1, b_addr2);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, done, c_valid} !== 3'b000) begin
      errors++;
      $display("FAIL idle_no_start busy=%b done=%b vld=%b want 000", busy, done, c_valid);
    end
  endtask

  task automatic test_ones();
    int dc, f, e;
    bit tmo;
    for (int x = 0; x < N*N; x++) begin amem[x] = 8'sd1; bmem[x] = 8'sd1; end
    run_job(-1, 0, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0) begin
      errors++;
      $display("FAIL ones_seq tmo=%0d bad=%0d first=%0d want 0", tmo, e, f);
    end
    checks++;
    if (q_d0.size() > 0 && (q_d0[0] != 8 || q_d1[0] != 8)) begin
      errors++;
      $display("FAIL ones_value got %0d/%0d want 8/8", q_d0[0], q_d1[0]);
    end
    checks++;
    if (dc != N*N/2*(N+2)+1) begin
      errors++;
      $display("FAIL ones_done_cycle got %0d want %0d", dc, N*N/2*(N+2)+1);
    end
    checks++;
    if (busy_low != 0 || addr_bad != 0) begin
      errors++;
      $display("FAIL ones_busy_addr busy_low=%0d addr_bad=%0d want 0/0", busy_low, addr_bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ones_after_done done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_extremes();
    int dc, f, e;
    bit tmo;
    for (int x = 0; x < N*N; x++) begin amem[x] = -8'sd128; bmem[x] = -8'sd128; end
    run_job(-1, 0, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0 || q_d0.size() == 0 || q_d0[N*N/2-1] != 131072) begin
      errors++;
      $display("FAIL neg_neg tmo=%0d bad=%0d first=%0d want 131072 everywhere", tmo, e, f);
    end
    for (int x = 0; x < N*N; x++) bmem[x] = 8'sd127;
    run_job(-1, 0, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0 || q_d1.size() == 0 || q_d1[0] != -130048) begin
      errors++;
      $display("FAIL neg_pos tmo=%0d bad=%0d first=%0d want -130048 everywhere", tmo, e, f);
    end
  endtask

  task automatic test_identity();
    int dc, f, e;
    bit tmo;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        amem[r*N+c] = (r == c) ? 8'sd1 : 8'sd0;
        bmem[r*N+c] = DW'(r*8 + c - 32);
      end
    run_job(-1, 0, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0) begin
      errors++;
      $display("FAIL ident_seq tmo=%0d bad=%0d first=%0d want 0", tmo, e, f);
    end
    checks++;
    if (q_row.size() != N*N/2 || q_row[31] != 7 || q_col[31] != 6 || q_d1[31] != 31) begin
      errors++;
      $display("FAIL ident_last size=%0d want last pair (7,6) c1=31", q_row.size());
    end
  endtask

  task automatic test_backpressure();
    int dc, f, e;
    bit tmo;
    fill_rand();
    run_job(3, 5, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (stall_seen != 5 || stall_diff != 0) begin
      errors++;
      $display("FAIL bp_hold seen=%0d diffs=%0d want 5/0", stall_seen, stall_diff);
    end
    checks++;
    if (tmo || e != 0) begin
      errors++;
      $display("FAIL bp_seq tmo=%0d bad=%0d first=%0d want 0", tmo, e, f);
    end
    checks++;
    if (dc != N*N/2*(N+2)+1+5) begin
      errors++;
      $display("FAIL bp_done_cycle got %0d want %0d", dc, N*N/2*(N+2)+6);
    end
  endtask

  task automatic test_start_busy();
    int dc, f, e;
    bit tmo;
    fill_rand();
    run_job(-1, 0, 1'b1, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0 || dc != N*N/2*(N+2)+1) begin
      errors++;
      $display("FAIL start_busy tmo=%0d bad=%0d done_cyc=%0d want 0 bad, 321", tmo, e, dc);
    end
  endtask

  task automatic test_reset_midrun();
    int dc, f, e;
    bit tmo;
    fill_rand();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (104) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || c_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_state busy=%b vld=%b want 1/0", busy, c_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, c_valid, a_addr, b_addr1, b_addr2, c_row, c_col, c_data0, c_data1} !== '0) begin
      errors++;
      $display("FAIL midrun_reset busy=%b a=%0d row=%0d col=%0d want all 0", busy, a_addr, c_row, c_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(-1, 0, 1'b0, 1'b0, dc, tmo);
    e = seq_errs(f);
    checks++;
    if (tmo || e != 0 || dc != N*N/2*(N+2)+1) begin
      errors++;
      $display("FAIL midrun_restart tmo=%0d bad=%0d first=%0d done_cyc=%0d", tmo, e, f, dc);
    end
  endtask

  task automatic test_random();
    int dc, f, e;
    bit tmo;
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      run_job(-1, 0, 1'b0, 1'b1, dc, tmo);
      e = seq_errs(f);
      checks++;
      if (tmo || e != 0 || addr_bad != 0) begin
        errors++;
        $display("FAIL random_%0d tmo=%0d bad=%0d first=%0d addr_bad=%0d", t, tmo, e, f, addr_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_extremes();
    test_identity();
    test_backpressure();
    test_start_busy();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
